// File: rtl/reg32_serial_tx_if.sv
`default_nettype none
// ============================================================================
// reg32_serial_tx_if
//   Word-load and serial-line bundle for the 32-bit register transmitter.
//   master: register-side source driving data_in/load and observing status.
//   slave : the transmitter itself.
//   Revision: 1.0
// ============================================================================
interface reg32_serial_tx_if;
   logic [31:0] data_in;
   logic        load;
   logic        busy;
   logic        tx;
   logic        done;

   modport master (
      output data_in,
      output load,
      input  busy,
      input  tx,
      input  done
   );

   modport slave (
      input  data_in,
      input  load,
      output busy,
      output tx,
      output done
   );
endinterface
`default_nettype wire

// File: rtl/reg32_serial_tx.sv
`default_nettype none
// ============================================================================
// reg32_serial_tx
//   Captures a 32-bit word and sends it on a UART-style line as four 8N1
//   frames, least significant byte first. Frames of one word run back to back
//   with no idle gap; done pulses in the first idle cycle after the word.
//   Revision: 1.0
// ============================================================================
module reg32_serial_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  wire logic        clk,
   input  wire logic        reset,   // asynchronous, active low
   reg32_serial_tx_if.slave bus
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t            state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [2:0]        bit_idx_q;
   logic [1:0]        byte_idx_q;
   logic [31:0]       shift_q;
   logic              tx_q;
   logic              busy_q;
   logic              done_q;

   logic [BAUD_W-1:0] baud_d;
   logic [2:0]        bit_idx_d;
   logic [1:0]        byte_idx_d;
   logic              bit_end;
   logic [7:0]        cur_byte;

   // The byte on the line is always the low byte; the register shifts right
   // by 8 as each stop bit ends.
   assign cur_byte   = shift_q[7:0];
   assign baud_d     = baud_q + 1'b1;
   assign bit_idx_d  = bit_idx_q + 3'd1;
   assign byte_idx_d = byte_idx_q + 2'd1;
   assign bit_end    = (baud_q == BAUD_LAST);

   // Transmit FSM: every bit period is exactly CLKS_PER_BIT cycles, so the
   // baud counter restarts at every boundary and cannot accumulate drift.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               baud_q <= '0;
               // A load in the done cycle is accepted, giving exactly one
               // idle-high cycle between consecutive words.
               if (bus.load) begin
                  shift_q    <= bus.data_in;
                  byte_idx_q <= '0;
                  bit_idx_q  <= '0;
                  state_q    <= START;
                  busy_q     <= 1'b1;
                  tx_q       <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  state_q   <= DATA;
                  tx_q      <= cur_byte[0];
               end else begin
                  baud_q <= baud_d;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_idx_q <= bit_idx_d;
                     tx_q      <= cur_byte[bit_idx_d];
                  end
               end else begin
                  baud_q <= baud_d;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_q <= '0;
                  if (byte_idx_q != 2'd3) begin
                     byte_idx_q <= byte_idx_d;
                     shift_q    <= {8'h00, shift_q[31:8]};
                     state_q    <= START;
                     tx_q       <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     tx_q    <= 1'b1;
                  end
               end else begin
                  baud_q <= baud_d;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx   = tx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg32_serial_tx.sv
`default_nettype none
// ============================================================================
// tb_reg32_serial_tx
//   Bench for reg32_serial_tx: a fast instance (4 clocks/bit) for framing and
//   handshake behaviour, and a 434 clocks/bit instance for baud timing.
//   Revision: 1.0
// ============================================================================
module tb_reg32_serial_tx;

   localparam int N    = 4;
   localparam int NB   = 434;
   localparam int BUSY = 40 * N;

   logic clk     = 1'b0;
   bit   clk_run = 1'b0;
   logic rst_n   = 1'b1;

   always #5 if (clk_run) clk = ~clk;

   reg32_serial_tx_if bus4();
   reg32_serial_tx_if bus6();

   reg32_serial_tx #(.CLKS_PER_BIT(N)) u_dut4 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus4.slave)
   );

   reg32_serial_tx #(.CLKS_PER_BIT(NB)) u_dut6 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus6.slave)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- line receiver on the fast instance -------------------
   logic [7:0] rx_bytes[$];
   bit         rx_ferr[$];
   int         done_cnt = 0;

   initial begin : rx_mon
      int   cnt;
      int   k;
      bit   active;
      bit   bad;
      logic prev;
      logic [7:0] sh;
      active = 1'b0;
      prev   = 1'b1;
      cnt    = 0;
      bad    = 1'b0;
      sh     = '0;
      forever begin
         @(negedge clk);
         if (bus4.done === 1'b1) done_cnt++;
         if (rst_n !== 1'b1) begin
            active = 1'b0;
            prev   = 1'b1;
         end else begin
            if (!active) begin
               if (prev === 1'b1 && bus4.tx === 1'b0) begin
                  active = 1'b1;
                  cnt    = 0;
                  bad    = 1'b0;
               end
            end else begin
               cnt++;
            end
            if (active && (cnt % N) == N / 2) begin
               k = cnt / N;
               if (k == 0) begin
                  if (bus4.tx !== 1'b0) bad = 1'b1;
               end else if (k <= 8) begin
                  sh[k-1] = bus4.tx;
               end else begin
                  if (bus4.tx !== 1'b1) bad = 1'b1;
                  rx_bytes.push_back(sh);
                  rx_ferr.push_back(bad);
                  active = 1'b0;
               end
            end
            prev = bus4.tx;
         end
      end
   end

   // ---------------- scoreboard -------------------------------------------
   logic [7:0] exp_q[$];
   int         rx_rd = 0;

   task automatic push_word(input logic [31:0] d);
      for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
   endtask

   task automatic drain();
      logic [7:0] b;
      while (rx_rd < rx_bytes.size()) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_byte: got %h expected none", rx_bytes[rx_rd]);
         end else begin
            b = exp_q.pop_front();
            check("rx_byte", 32'(rx_bytes[rx_rd]), 32'(b));
            check("rx_framing", 32'(rx_ferr[rx_rd]), 32'd0);
         end
         rx_rd++;
      end
   endtask

   // Sends one word on the fast instance, optionally pulsing a competing load
   // mid-word, and checks busy length and the done pulse.
   task automatic send_word(input logic [31:0] d, input bit glitch, input int exp_busy);
      int cnt;
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      bus4.data_in = d;
      bus4.load    = 1'b1;
      push_word(d);
      @(negedge clk);
      bus4.load = 1'b0;
      cnt = 0;
      while (bus4.busy === 1'b1 && cnt < 2 * exp_busy) begin
         cnt++;
         if (glitch) begin
            bus4.data_in = 32'hDEADBEEF;
            bus4.load    = (cnt == 5 || cnt == 100);
         end
         @(negedge clk);
      end
      bus4.load = 1'b0;
      check("busy_len", 32'(cnt), 32'(exp_busy));
      check("done_busy_tx_at_end", 32'({bus4.done, bus4.busy, bus4.tx}), 32'b101);
      @(negedge clk);
      check("done_one_cycle", 32'(bus4.done), 32'd0);
      check("done_count", 32'(done_cnt - d0), 32'd1);
      drain();
   endtask

   typedef struct {
      logic [31:0] data;
      bit          glitch;
      int          exp_busy;
   } vec_t;

   vec_t vecs[5];

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int   cnt;
      int   d0;
      int   bp;
      int   tx_err;
      int   sp_err;
      logic prev;
      logic expb;
      logic [31:0] d6;

      vecs[0] = '{32'hA55A0F81, 1'b0, BUSY};
      vecs[1] = '{32'h12345678, 1'b1, BUSY};
      vecs[2] = '{32'h00000000, 1'b0, BUSY};
      vecs[3] = '{32'hFFFFFFFF, 1'b0, BUSY};
      vecs[4] = '{32'h80000001, 1'b0, BUSY};

      bus4.data_in = '0;
      bus4.load    = 1'b0;
      bus6.data_in = '0;
      bus6.load    = 1'b0;

      // Reset applied with the clock stopped; outputs must settle at once.
      #20;
      rst_n = 1'b0;
      #1;
      check("reset_outputs", 32'({bus4.tx, bus4.busy, bus4.done}), 32'b100);
      check("reset_outputs_slow", 32'({bus6.tx, bus6.busy, bus6.done}), 32'b100);
      #10;
      rst_n   = 1'b1;
      clk_run = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus4.tx !== 1'b1 || bus4.busy !== 1'b0) cnt++;
      end
      check("idle_after_reset", 32'(cnt), 32'd0);

      // Table-driven single words, including the ignored-load case.
      for (int v = 0; v < 5; v++) send_word(vecs[v].data, vecs[v].glitch, vecs[v].exp_busy);

      // Back-to-back with load held high.
      d0 = done_cnt;
      @(negedge clk);
      bus4.data_in = 32'h00000000;
      bus4.load    = 1'b1;
      push_word(32'h00000000);
      @(negedge clk);
      bus4.data_in = 32'hFFFFFFFF;
      push_word(32'hFFFFFFFF);
      cnt = 0;
      while (bus4.busy === 1'b1 && cnt < 2 * BUSY) begin
         cnt++;
         @(negedge clk);
      end
      check("b2b_first_busy_len", 32'(cnt), 32'(BUSY));
      check("b2b_gap_done_busy_tx", 32'({bus4.done, bus4.busy, bus4.tx}), 32'b101);
      @(negedge clk);
      check("b2b_second_start", 32'({bus4.busy, bus4.tx}), 32'b10);
      bus4.load = 1'b0;
      cnt = 1;
      @(negedge clk);
      while (bus4.busy === 1'b1 && cnt < 2 * BUSY) begin
         cnt++;
         @(negedge clk);
      end
      check("b2b_second_busy_len", 32'(cnt), 32'(BUSY));
      check("b2b_second_done", 32'(bus4.done), 32'd1);
      @(negedge clk);
      check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
      drain();

      // Reset during the data bits of byte 2.
      @(negedge clk);
      bus4.data_in = 32'h12345678;
      bus4.load    = 1'b1;
      push_word(32'h12345678);
      @(negedge clk);
      bus4.load = 1'b0;
      repeat (94) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midop_reset_outputs", 32'({bus4.tx, bus4.busy, bus4.done}), 32'b100);
      @(negedge clk);
      drain();
      check("midop_pending_bytes", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send_word(32'h000000FF, 1'b0, BUSY);

      // Baud accuracy at the nominal rate.
      d6 = 32'h55555555;
      @(negedge clk);
      bus6.data_in = d6;
      bus6.load    = 1'b1;
      @(negedge clk);
      bus6.load = 1'b0;
      cnt    = 0;
      tx_err = 0;
      sp_err = 0;
      prev   = 1'b1;
      while (bus6.busy === 1'b1 && cnt < 2 * 40 * NB) begin
         bp = cnt / NB;
         if (bp >= 40)            expb = 1'b1;
         else if (bp % 10 == 0)   expb = 1'b0;
         else if (bp % 10 == 9)   expb = 1'b1;
         else                     expb = d6[(bp / 10) * 8 + (bp % 10) - 1];
         if (bus6.tx !== expb) tx_err++;
         if (bus6.tx !== prev && (cnt % NB) != 0) sp_err++;
         prev = bus6.tx;
         cnt++;
         @(negedge clk);
      end
      check("slow_busy_len", 32'(cnt), 32'(40 * NB));
      check("slow_tx_pattern_errs", 32'(tx_err), 32'd0);
      check("slow_spacing_errs", 32'(sp_err), 32'd0);
      check("slow_done_busy", 32'({bus6.done, bus6.busy}), 32'b10);

      drain();
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
